// File: rtl/vend_pkg.sv
// vend_pkg: shared types and helpers for the vending-core request arbiter.
//   status_t   - result code returned to a panel
//   state_t    - arbiter FSM state encoding
//   idx_w      - width of an index into n entries (at least 1 bit)
//   item_w     - item index width for a given item count
//   cur_w      - currency width for a given currency range
//   empty_item - item code the core uses to report "sold out"
package vend_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_SOLD_OUT = 2'd1,
    ST_REJECTED = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_SEL_WAIT = 3'd2,
    S_PAY_HI   = 3'd3,
    S_PAY_LO   = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  // Counter width shared by the gap, hold and timeout phases.
  localparam int CNT_W = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int item_w(input int max_items);
    return (max_items <= 2) ? 1 : $clog2(max_items);
  endfunction

  function automatic int cur_w(input int max_currency);
    return (max_currency <= 2) ? 1 : $clog2(max_currency);
  endfunction

  // The core answers an item select with the last item code when the
  // selected item is sold out.
  function automatic int empty_item(input int max_items);
    return max_items - 1;
  endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// vend_rr_arbiter: combinational round-robin pick over NUM_REQ requesters.
// The search starts at ptr and walks upward with wrap-around; the first
// active request found wins.
//   req       in  NUM_REQ  request vector
//   ptr       in  PW       highest-priority index (must be < NUM_REQ)
//   grant     out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out PW       index of the granted requester
//   any       out 1        at least one request is active
module vend_rr_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SW = PW + 1;

  logic [SW-1:0]      cand_sum [NUM_REQ];
  logic [PW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  // Candidate gi is the requester gi positions above ptr, modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr} + SW'(gi);
      assign cand_idx[gi] = PW'((cand_sum[gi] >= SW'(NUM_REQ)) ?
                                (cand_sum[gi] - SW'(NUM_REQ)) : cand_sum[gi]);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest active one wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_idx = cand_idx[i];
        any       = 1'b1;
      end
    end
    grant = '0;
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vend_request_arbiter.sv
// vend_request_arbiter: shares one vending core among NUM_REQ panels.
// A request (item, payment) is captured round-robin, the item is selected
// on the core, a sold-out reply is awaited for SEL_GAP cycles, the payment
// is presented for CUR_HOLD cycles, and the dispense result is awaited for
// up to TIMEOUT cycles. The outcome goes back to the granted panel.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/item/amount    packed per-panel request (slice k = panel k)
//   req_ready                one-hot capture acknowledge (one cycle)
//   rsp_valid/status/change  one-hot result strobe, result code, change
//   busy                     high whenever the FSM is not idle
//   vm_item_select_valid/_select, vm_currency_valid/_value  to core
//   vm_item_dispense_valid/_dispense, vm_currency_change    from core
module vend_request_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_ITEMS    = 1024,
  parameter int MAX_CURRENCY = 100,
  parameter int SEL_GAP      = 4,
  parameter int CUR_HOLD     = 8,
  parameter int TIMEOUT      = 255,
  localparam int IW = item_w(MAX_ITEMS),
  localparam int CW = cur_w(MAX_CURRENCY),
  localparam int PW = idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*IW-1:0] req_item,
  input  logic [NUM_REQ*CW-1:0] req_amount,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [CW-1:0]         rsp_change,
  output logic                  busy,
  output logic                  vm_item_select_valid,
  output logic [IW-1:0]         vm_item_select,
  output logic                  vm_currency_valid,
  output logic [CW-1:0]         vm_currency_value,
  input  logic                  vm_item_dispense_valid,
  input  logic [IW-1:0]         vm_item_dispense,
  input  logic [CW-1:0]         vm_currency_change
);

  localparam logic [IW-1:0]    EMPTY_C    = IW'(empty_item(MAX_ITEMS));
  localparam logic [CNT_W-1:0] SEL_GAP_C  = CNT_W'(SEL_GAP);
  localparam logic [CNT_W-1:0] CUR_HOLD_C = CNT_W'(CUR_HOLD);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [PW-1:0]    LAST_IDX   = PW'(NUM_REQ - 1);

  state_t             state_reg;
  logic [PW-1:0]      rr_ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IW-1:0]      item_reg;
  logic [CW-1:0]      amount_reg;
  logic [NUM_REQ-1:0] gnt_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  vend_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // All outputs are registered and loaded with the value they must carry
  // in the state being entered, so each state's outputs are valid from its
  // first cycle. cnt_reg starts at 1 on entry to a timed state and the
  // state is left on the cycle where it equals the phase length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= S_IDLE;
      rr_ptr_reg           <= '0;
      cnt_reg              <= '0;
      item_reg             <= '0;
      amount_reg           <= '0;
      gnt_reg              <= '0;
      req_ready            <= '0;
      rsp_valid            <= '0;
      rsp_status           <= '0;
      rsp_change           <= '0;
      busy                 <= 1'b0;
      vm_item_select_valid <= 1'b0;
      vm_item_select       <= '0;
      vm_currency_valid    <= 1'b0;
      vm_currency_value    <= '0;
    end else begin
      // One-cycle strobes default low.
      req_ready            <= '0;
      rsp_valid            <= '0;
      vm_item_select_valid <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (arb_any) begin
            item_reg             <= req_item[arb_idx*IW +: IW];
            amount_reg           <= req_amount[arb_idx*CW +: CW];
            gnt_reg              <= arb_grant;
            rr_ptr_reg           <= (arb_idx == LAST_IDX) ? '0 : arb_idx + PW'(1);
            req_ready            <= arb_grant;
            vm_item_select_valid <= 1'b1;
            vm_item_select       <= req_item[arb_idx*IW +: IW];
            busy                 <= 1'b1;
            state_reg            <= S_SELECT;
          end
        end

        S_SELECT: begin
          vm_item_select <= '0;
          cnt_reg        <= CNT_W'(1);
          state_reg      <= S_SEL_WAIT;
        end

        S_SEL_WAIT: begin
          // Only the sold-out code is meaningful here; other replies are
          // stale and dropped.
          if (vm_item_dispense_valid && (vm_item_dispense == EMPTY_C)) begin
            rsp_valid  <= gnt_reg;
            rsp_status <= ST_SOLD_OUT;
            rsp_change <= amount_reg;
            cnt_reg    <= '0;
            state_reg  <= S_RESP;
          end else if (cnt_reg == SEL_GAP_C) begin
            vm_currency_valid <= 1'b1;
            vm_currency_value <= amount_reg;
            cnt_reg           <= CNT_W'(1);
            state_reg         <= S_PAY_HI;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_PAY_HI: begin
          // The core latches the payment on the falling edge of
          // currency_valid, so the value stays up through PAY_LO.
          if (cnt_reg == CUR_HOLD_C) begin
            vm_currency_valid <= 1'b0;
            cnt_reg           <= CNT_W'(1);
            state_reg         <= S_PAY_LO;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_PAY_LO: begin
          // A result arriving on the last counted cycle still beats the
          // timeout.
          if (vm_item_dispense_valid) begin
            rsp_valid         <= gnt_reg;
            vm_currency_value <= '0;
            cnt_reg           <= '0;
            state_reg         <= S_RESP;
            if (vm_item_dispense == item_reg) begin
              rsp_status <= ST_OK;
              rsp_change <= vm_currency_change;
            end else begin
              rsp_status <= ST_REJECTED;
              rsp_change <= amount_reg;
            end
          end else if (cnt_reg == TIMEOUT_C) begin
            rsp_valid         <= gnt_reg;
            rsp_status        <= ST_TIMEOUT;
            rsp_change        <= amount_reg;
            vm_currency_value <= '0;
            cnt_reg           <= '0;
            state_reg         <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_RESP: begin
          rsp_status <= '0;
          rsp_change <= '0;
          busy       <= 1'b0;
          state_reg  <= S_IDLE;
        end

        default: begin
          vm_currency_valid <= 1'b0;
          vm_currency_value <= '0;
          vm_item_select    <= '0;
          busy              <= 1'b0;
          cnt_reg           <= '0;
          state_reg         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_request_arbiter.sv
module tb_vend_request_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int IW       = 10;
  localparam int CW       = 7;
  localparam int SEL_GAP  = 4;
  localparam int CUR_HOLD = 8;
  localparam int TIMEOUT  = 255;
  localparam int OK_LAT   = SEL_GAP + CUR_HOLD + 3;

  localparam int C_OK = 0, C_SOLD = 1, C_REJ = 2, C_TMO = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*IW-1:0] req_item = '0;
  logic [NUM_REQ*CW-1:0] req_amount = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [1:0]            rsp_status;
  logic [CW-1:0]         rsp_change;
  logic                  busy;
  logic                  vm_item_select_valid;
  logic [IW-1:0]         vm_item_select;
  logic                  vm_currency_valid;
  logic [CW-1:0]         vm_currency_value;
  logic                  vm_item_dispense_valid = 1'b0;
  logic [IW-1:0]         vm_item_dispense = '0;
  logic [CW-1:0]         vm_currency_change = '0;

  vend_request_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_ITEMS(1024), .MAX_CURRENCY(100),
    .SEL_GAP(SEL_GAP), .CUR_HOLD(CUR_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_item(req_item), .req_amount(req_amount),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_change(rsp_change), .busy(busy),
    .vm_item_select_valid(vm_item_select_valid), .vm_item_select(vm_item_select),
    .vm_currency_valid(vm_currency_valid), .vm_currency_value(vm_currency_value),
    .vm_item_dispense_valid(vm_item_dispense_valid),
    .vm_item_dispense(vm_item_dispense), .vm_currency_change(vm_currency_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int panel;
    int status;
    int change;
    int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int ready_cnt = 0;
  int cur_hi_cnt = 0;
  int cap_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every response strobe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 1);
        ready_cnt++;
        cap_cyc = cyc - 1;
        $display("txn: capture panel %0d at cycle %0d", oh_idx(req_ready), cap_cyc);
      end
      if (vm_currency_valid) cur_hi_cnt++;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          $display("txn: rsp panel %0d status %0d change %0d latency %0d",
                   oh_idx(rsp_valid), rsp_status, rsp_change, cyc - cap_cyc);
          check("rsp_panel", 32'(rsp_valid), 32'(1) << e.panel);
          check("rsp_status", 32'(rsp_status), e.status);
          check("rsp_change", 32'(rsp_change), e.change);
          if (e.lat >= 0) check("rsp_latency", cyc - cap_cyc, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic request(input int p, input int item, input int amt);
    bit seen;
    seen = 1'b0;
    req_item[p*IW +: IW]   = IW'(item);
    req_amount[p*CW +: CW] = CW'(amt);
    req_valid[p] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready[p]) begin
        seen = 1'b1;
        break;
      end
    end
    check("req_ready_seen", 32'(seen), 1);
    if (seen) begin
      check("item_select_valid", 32'(vm_item_select_valid), 1);
      check("item_select", 32'(vm_item_select), item);
    end
    req_valid[p] = 1'b0;
  endtask

  // Follows PAY_HI and returns in the first PAY_LO cycle.
  task automatic wait_pay_lo(input int amt, output int lo_cyc);
    int hi;
    bit done;
    hi = 0;
    done = 1'b0;
    lo_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      if (vm_currency_valid) begin
        hi++;
        if (hi == 1) begin
          check("pay_hi_start", cyc - cap_cyc, 2 + SEL_GAP);
          check("currency_value", 32'(vm_currency_value), amt);
        end
      end else if (hi > 0) begin
        done = 1'b1;
        lo_cyc = cyc;
        break;
      end
      tick();
    end
    check("pay_lo_reached", 32'(done), 1);
    check("pay_hi_cycles", hi, CUR_HOLD);
    check("currency_value_held", 32'(vm_currency_value), amt);
  endtask

  task automatic core_result(input int item, input int change);
    vm_item_dispense_valid = 1'b1;
    vm_item_dispense       = IW'(item);
    vm_currency_change     = CW'(change);
    tick();
    vm_item_dispense_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int cur0;
    int rc0;
    int g;
    int ge;
    bit seen;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_status", 32'(rsp_status), 0);
    check("rst_rsp_change", 32'(rsp_change), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel_valid", 32'(vm_item_select_valid), 0);
    check("rst_sel_item", 32'(vm_item_select), 0);
    check("rst_cur_valid", 32'(vm_currency_valid), 0);
    check("rst_cur_value", 32'(vm_currency_value), 0);
    rst = 1'b0;
    tick();

    // Single request, OK at minimum latency
    sb.push_back('{panel: 1, status: C_OK, change: 5, lat: OK_LAT});
    request(1, 3, 20);
    check("busy_in_select", 32'(busy), 1);
    wait_pay_lo(20, lo);
    core_result(3, 5);
    wait_rsp("single_done", 10);
    tick();
    check("busy_after_single", 32'(busy), 0);

    // Dispense result while idle must be ignored
    core_result(3, 5);
    tick();
    tick();
    check("idle_ignore_busy", 32'(busy), 0);

    // Sold out reported in the 2nd SEL_WAIT cycle, non-empty reply ignored
    sb.push_back('{panel: 2, status: C_SOLD, change: 33, lat: 4});
    request(2, 9, 33);
    cur0 = cur_hi_cnt;
    tick();
    core_result(9, 0);
    core_result(1023, 0);
    wait_rsp("soldout_done", 10);
    tick();
    tick();
    check("soldout_no_payment", cur_hi_cnt - cur0, 0);

    // Reject: core dispenses a different item
    sb.push_back('{panel: 0, status: C_REJ, change: 7, lat: OK_LAT});
    request(0, 44, 7);
    wait_pay_lo(7, lo);
    core_result(1023, 7);
    wait_rsp("reject_done", 10);
    tick();

    // Timeout: core silent after payment
    sb.push_back('{panel: 3, status: C_TMO, change: 55,
                   lat: SEL_GAP + CUR_HOLD + 2 + TIMEOUT});
    request(3, 100, 55);
    wait_pay_lo(55, lo);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (rsp_valid != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_rsp_seen", 32'(seen), 1);
    check("timeout_cycles", cyc - lo, TIMEOUT);
    check("timeout_busy_in_resp", 32'(busy), 1);
    tick();
    check("timeout_busy_drop", 32'(busy), 0);

    // Fairness: all panels request continuously
    for (int p = 0; p < NUM_REQ; p++) begin
      req_item[p*IW +: IW]   = IW'(10 + p);
      req_amount[p*CW +: CW] = CW'(20 + p);
    end
    rc0 = ready_cnt;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      g = -1;
      ge = k % NUM_REQ;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (req_ready != '0) begin
          g = oh_idx(req_ready);
          break;
        end
      end
      if (k == 7) req_valid = '0;
      check("grant_order", g, ge);
      sb.push_back('{panel: ge, status: C_OK, change: ge, lat: OK_LAT});
      wait_pay_lo(20 + ge, lo);
      core_result(10 + ge, ge);
      wait_rsp("fair_done", 10);
    end
    check("ready_per_txn", ready_cnt - rc0, 8);
    tick();
    tick();

    // Reset in the middle of PAY_HI
    request(2, 5, 9);
    for (int i = 0; i < 20; i++) begin
      if (vm_currency_valid) break;
      tick();
    end
    check("payhi_reached", 32'(vm_currency_valid), 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_cur_valid", 32'(vm_currency_valid), 0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_cur_value", 32'(vm_currency_value), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    req_item[3*IW +: IW]   = IW'(77);
    req_amount[3*CW +: CW] = CW'(40);
    req_valid[3] = 1'b1;
    sb.push_back('{panel: 0, status: C_OK, change: 1, lat: OK_LAT});
    request(0, 12, 30);
    req_valid = '0;
    wait_pay_lo(30, lo);
    core_result(12, 1);
    wait_rsp("post_reset_done", 10);
    tick();
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
